// File: rtl/assoc_cache_ctrl_if.sv
// CPU request port and backing-memory port of assoc_cache_ctrl.
// The controller connects through modport slave; the requester/memory side uses master.
interface assoc_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic              cpu_valid;
  logic              cpu_opcode;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data_in;
  logic              cpu_ready;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_data_out;
  logic              cpu_hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_valid, cpu_opcode, cpu_address, cpu_data_in, mem_ack, mem_rdata,
    output cpu_ready, cpu_done, cpu_data_out, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_valid, cpu_opcode, cpu_address, cpu_data_in, mem_ack, mem_rdata,
    input  cpu_ready, cpu_done, cpu_data_out, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache controller with true LRU per set.
// Optional macro CACHE_STATS_EN builds the access/hit counters; otherwise they read as 0.
module assoc_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int SETS   = 16,
  parameter int WAYS   = 4
) (
  input  logic                clk,
  input  logic                rst_b,
  assoc_cache_ctrl_if.slave   bus,
  output logic [31:0]         access_cnt,
  output logic [31:0]         hit_cnt
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [DATA_W-1:0] data_q [SETS][WAYS];
  logic [AGE_W-1:0]  age_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              cpu_done_q, cpu_done_d;
  logic [DATA_W-1:0] cpu_data_out_q, cpu_data_out_d;
  logic              cpu_hit_q, cpu_hit_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WAYS-1:0]   hit_vec;
  logic              hit_any;
  logic [WAY_W-1:0]  hit_way, victim;
  logic              line_we, line_dirty, touch_en;
  logic [WAY_W-1:0]  line_way, touch_way;
  logic [DATA_W-1:0] line_data;
  logic [AGE_W-1:0]  age_row_d [WAYS];

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  // Per-way tag match and the aged row that results from touching touch_way.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign hit_vec[gi]   = valid_q[idx][gi] && (tag_q[idx][gi] == tag);
      assign age_row_d[gi] = (WAY_W'(gi) == touch_way) ? '0 :
                             (age_q[idx][gi] < age_q[idx][touch_way]) ? age_q[idx][gi] + AGE_W'(1) :
                             age_q[idx][gi];
    end
  endgenerate

  // Later loop wins: the lowest-index invalid way overrides the oldest way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (age_q[idx][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim = WAY_W'(w);
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    victim_d       = victim_q;
    cpu_done_d     = 1'b0;
    cpu_data_out_d = cpu_data_out_q;
    cpu_hit_d      = cpu_hit_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    line_we        = 1'b0;
    line_way       = hit_way;
    line_data      = wdata_q;
    line_dirty     = 1'b0;
    touch_en       = 1'b0;
    touch_way      = hit_way;
    case (state_q)
      IDLE: begin
        if (bus.cpu_valid) begin
          op_d    = bus.cpu_opcode;
          addr_d  = bus.cpu_address;
          wdata_d = bus.cpu_data_in;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          touch_en       = 1'b1;
          line_we        = op_q;
          line_dirty     = 1'b1;
          cpu_data_out_d = op_q ? wdata_q : data_q[idx][hit_way];
          cpu_hit_d      = 1'b1;
          cpu_done_d     = 1'b1;
          state_d        = RESPOND;
        end else begin
          victim_d  = victim;
          mem_req_d = 1'b1;
          if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[idx][victim], idx};
            mem_wdata_d = data_q[idx][victim];
            state_d     = WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q;
            state_d    = REFILL;
          end
        end
      end
      WRITEBACK: begin
        if (mem_req_q && bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        // Coming from a writeback the request is down for one cycle before the refill is raised.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
        end else if (bus.mem_ack) begin
          mem_req_d      = 1'b0;
          line_we        = 1'b1;
          line_way       = victim_q;
          line_data      = op_q ? wdata_q : bus.mem_rdata;
          line_dirty     = op_q;
          touch_en       = 1'b1;
          touch_way      = victim_q;
          cpu_data_out_d = op_q ? wdata_q : bus.mem_rdata;
          cpu_hit_d      = 1'b0;
          cpu_done_d     = 1'b1;
          state_d        = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      op_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      victim_q       <= '0;
      cpu_done_q     <= 1'b0;
      cpu_data_out_q <= '0;
      cpu_hit_q      <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      victim_q       <= victim_d;
      cpu_done_q     <= cpu_done_d;
      cpu_data_out_q <= cpu_data_out_d;
      cpu_hit_q      <= cpu_hit_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx][line_way]  <= tag;
      data_q[idx][line_way] <= line_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      if (line_we) begin
        valid_q[idx][line_way] <= 1'b1;
        dirty_q[idx][line_way] <= line_dirty;
      end
      if (touch_en)
        for (int w = 0; w < WAYS; w++) age_q[idx][w] <= age_row_d[w];
    end
  end

  assign bus.cpu_ready    = (state_q == IDLE) && rst_b;
  assign bus.cpu_done     = cpu_done_q;
  assign bus.cpu_data_out = cpu_data_out_q;
  assign bus.cpu_hit      = cpu_hit_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] access_cnt_q, access_cnt_d, hit_cnt_q, hit_cnt_d;

  always_comb begin
    access_cnt_d = access_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    if (state_q == RESPOND) begin
      access_cnt_d = access_cnt_q + 32'd1;
      if (cpu_hit_q) hit_cnt_d = hit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      access_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else begin
      access_cnt_q <= access_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  assign access_cnt = access_cnt_q;
  assign hit_cnt    = hit_cnt_q;
`else
  assign access_cnt = '0;
  assign hit_cnt    = '0;
`endif
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: 16 sets, 4 ways, memory with a 2-cycle ack, mem[a] = a[7:0]^8'h5A.
module tb_assoc_cache_ctrl;
  logic        clk;
  logic        rst_b;
  logic [31:0] access_cnt, hit_cnt;

  assoc_cache_ctrl_if #(.ADDR_W(32), .DATA_W(8)) bus ();

  assoc_cache_ctrl #(.ADDR_W(32), .DATA_W(8), .SETS(16), .WAYS(4)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .bus        (bus.slave),
    .access_cnt (access_cnt),
    .hit_cnt    (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: ack in the second cycle of each request; logs every new request.
  logic        log_we    [64];
  logic [31:0] log_addr  [64];
  logic [7:0]  log_wdata [64];
  int          log_n    = 0;
  int          req_age  = 0;
  int          unstable = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr;

  assign bus.mem_rdata = bus.mem_addr[7:0] ^ 8'h5A;

  initial bus.mem_ack = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (!prev_req || prev_ack) begin
        req_age = 1;
        if (log_n < 64) begin
          log_we[log_n]    = bus.mem_we;
          log_addr[log_n]  = bus.mem_addr;
          log_wdata[log_n] = bus.mem_wdata;
        end
        log_n++;
      end else begin
        req_age++;
        if (bus.mem_addr !== prev_addr) unstable++;
      end
    end else begin
      req_age = 0;
    end
    bus.mem_ack = bus.mem_req && (req_age == 2);
    prev_req    = bus.mem_req;
    prev_ack    = bus.mem_ack;
    prev_addr   = bus.mem_addr;
  end

  task automatic do_req(input logic op, input logic [31:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic hit, output int lat,
                        output int nreq, output int first);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!bus.cpu_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) check_eq("ready_wait", 32'd0, 32'd1);
    first           = log_n;
    bus.cpu_valid   = 1'b1;
    bus.cpu_opcode  = op;
    bus.cpu_address = addr;
    bus.cpu_data_in = wd;
    @(posedge clk); #1;
    bus.cpu_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!bus.cpu_done && lat < 200);
    if (!bus.cpu_done) check_eq("done_wait", 32'd0, 32'd1);
    rd   = bus.cpu_data_out;
    hit  = bus.cpu_hit;
    nreq = log_n - first;
    $display("txn op=%0d addr=0x%0h wdata=0x%0h -> data=0x%0h hit=%0d lat=%0d memreqs=%0d",
             op, addr, wd, rd, hit, lat, nreq);
  endtask

  logic [7:0]  rd;
  logic        hit;
  int          lat, nreq, first, n, wb80;
  logic [31:0] exp_acc, exp_hit;

  initial begin
    rst_b           = 1'b0;
    bus.cpu_valid   = 1'b0;
    bus.cpu_opcode  = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_data_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(bus.cpu_ready), 32'd0);
    check_eq("rst_done", 32'(bus.cpu_done), 32'd0);
    check_eq("rst_data_out", 32'(bus.cpu_data_out), 32'd0);
    check_eq("rst_hit", 32'(bus.cpu_hit), 32'd0);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check_eq("rst_access_cnt", access_cnt, 32'd0);
    check_eq("rst_hit_cnt", hit_cnt, 32'd0);
    rst_b = 1'b1;
    @(negedge clk); #1;
    check_eq("ready_after_rst", 32'(bus.cpu_ready), 32'd1);

    // Read 0x10 twice: refill then hit.
    do_req(1'b0, 32'h10, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s1_miss_hit", 32'(hit), 32'd0);
    check_eq("s1_miss_data", 32'(rd), 32'h4A);
    check_eq("s1_miss_nreq", nreq, 32'd1);
    check_eq("s1_refill_addr", log_addr[first], 32'h10);
    check_eq("s1_refill_we", 32'(log_we[first]), 32'd0);
    check_eq("s1_miss_lat", lat, 32'd4);
    do_req(1'b0, 32'h10, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s1_hit_hit", 32'(hit), 32'd1);
    check_eq("s1_hit_data", 32'(rd), 32'h4A);
    check_eq("s1_hit_lat", lat, 32'd2);
    check_eq("s1_hit_nreq", nreq, 32'd0);
    @(negedge clk); #1;
    check_eq("s1_ready_again", 32'(bus.cpu_ready), 32'd1);
    check_eq("s1_done_pulse", 32'(bus.cpu_done), 32'd0);
`ifdef CACHE_STATS_EN
    exp_acc = 32'd2;
    exp_hit = 32'd1;
`else
    exp_acc = 32'd0;
    exp_hit = 32'd0;
`endif
    check_eq("stats_access", access_cnt, exp_acc);
    check_eq("stats_hit", hit_cnt, exp_hit);

    // Write-allocate, then read back from the cache.
    do_req(1'b1, 32'h80, 8'hA5, rd, hit, lat, nreq, first);
    check_eq("s2_wr_hit", 32'(hit), 32'd0);
    check_eq("s2_wr_data", 32'(rd), 32'hA5);
    check_eq("s2_wr_nreq", nreq, 32'd1);
    check_eq("s2_wr_refill_addr", log_addr[first], 32'h80);
    do_req(1'b0, 32'h80, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s2_rd_hit", 32'(hit), 32'd1);
    check_eq("s2_rd_data", 32'(rd), 32'hA5);
    wb80 = 0;
    for (int i = 0; i < log_n && i < 64; i++)
      if (log_we[i] && log_addr[i] == 32'h80) wb80++;
    check_eq("s2_mem80_untouched", wb80, 32'd0);

    // Fill set 0 and evict the dirty 0x100 line.
    do_req(1'b1, 32'h100, 8'h11, rd, hit, lat, nreq, first);
    do_req(1'b0, 32'h200, 8'h00, rd, hit, lat, nreq, first);
    do_req(1'b0, 32'h300, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s3_300_nreq", nreq, 32'd1);
    do_req(1'b0, 32'h400, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s3_400_wb_addr", log_addr[first], 32'h80);
    check_eq("s3_400_wb_data", 32'(log_wdata[first]), 32'hA5);
    do_req(1'b0, 32'h500, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s3_500_hit", 32'(hit), 32'd0);
    check_eq("s3_500_data", 32'(rd), 32'h5A);
    check_eq("s3_500_nreq", nreq, 32'd2);
    check_eq("s3_wb_we", 32'(log_we[first]), 32'd1);
    check_eq("s3_wb_addr", log_addr[first], 32'h100);
    check_eq("s3_wb_data", 32'(log_wdata[first]), 32'h11);
    check_eq("s3_refill_we", 32'(log_we[first+1]), 32'd0);
    check_eq("s3_refill_addr", log_addr[first+1], 32'h500);
    check_eq("s3_500_lat", lat, 32'd7);

    // LRU touch of 0x200 protects it; 0x300 becomes the victim.
    do_req(1'b0, 32'h200, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s4_200_hit", 32'(hit), 32'd1);
    check_eq("s4_200_data", 32'(rd), 32'h5A);
    do_req(1'b0, 32'h600, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s4_600_nreq", nreq, 32'd1);
    check_eq("s4_600_we", 32'(log_we[first]), 32'd0);
    check_eq("s4_600_addr", log_addr[first], 32'h600);
    do_req(1'b0, 32'h200, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s4_200_still_hit", 32'(hit), 32'd1);

    // Dirty 0x200, then reset in the middle of a refill.
    do_req(1'b1, 32'h200, 8'h33, rd, hit, lat, nreq, first);
    check_eq("s5_wr_hit", 32'(hit), 32'd1);
    @(negedge clk); #1;
    n = 0;
    while (!bus.cpu_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    bus.cpu_valid   = 1'b1;
    bus.cpu_opcode  = 1'b0;
    bus.cpu_address = 32'h700;
    @(posedge clk); #1;
    bus.cpu_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.mem_req && n < 50);
    check_eq("s5_req_seen", 32'(bus.mem_req), 32'd1);
    rst_b = 1'b0;
    @(negedge clk); #1;
    check_eq("s5_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("s5_rst_done", 32'(bus.cpu_done), 32'd0);
    check_eq("s5_rst_ready", 32'(bus.cpu_ready), 32'd0);
    rst_b = 1'b1;
    @(negedge clk); #1;
    check_eq("s5_rel_ready", 32'(bus.cpu_ready), 32'd1);
    check_eq("s5_rel_done", 32'(bus.cpu_done), 32'd0);
    do_req(1'b0, 32'h200, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s5_200_hit", 32'(hit), 32'd0);
    check_eq("s5_200_data", 32'(rd), 32'h5A);
    check_eq("s5_200_nreq", nreq, 32'd1);
    check_eq("s5_200_we", 32'(log_we[first]), 32'd0);
    do_req(1'b0, 32'h10, 8'h00, rd, hit, lat, nreq, first);
    check_eq("s5_10_hit", 32'(hit), 32'd0);
    check_eq("s5_10_data", 32'(rd), 32'h4A);

    check_eq("mem_stable", unstable, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
